// File: rtl/qracc_psum_acc.sv
// qracc_psum_acc: partial-sum accumulator behind seq_acc.
// Captures one input vector per valid_i and sums cfg_num_tiles of them
// (one per weight tile). It then requantizes the sum (arithmetic shift,
// optional ReLU, saturation) into a one-entry valid/ready output register.
// The input never stalls. A completed group that finds the output register
// full and not popping is dropped, and ovf_o is set.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   cfg_num_tiles   tiles per group (0 -> 1, clamped to maxTiles)
//   cfg_shift       arithmetic right shift of the final sum
//   cfg_relu        force negative results to zero
//   clear_i         abort the in-progress group (wins over valid_i)
//   valid_i, data_i input tile vector (numCols x inBits, signed)
//   valid_o, ready_i, data_o  requantized output vector handshake
//   busy_o          a group is partially accumulated
//   tile_cnt_o      tiles accumulated in the current group
//   ovf_o           sticky: a completed group was dropped
module qracc_psum_acc #(
  parameter int unsigned numCols  = 32,
  parameter int unsigned inBits   = 8,
  parameter int unsigned outBits  = 8,
  parameter int unsigned maxTiles = 16,
  localparam int unsigned accBits  = inBits + $clog2(maxTiles),
  localparam int unsigned tileBits = $clog2(maxTiles + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [tileBits-1:0]         cfg_num_tiles,
  input  logic [3:0]                  cfg_shift,
  input  logic                        cfg_relu,
  input  logic                        clear_i,
  input  logic                        valid_i,
  input  logic [numCols*inBits-1:0]   data_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [numCols*outBits-1:0]  data_o,
  output logic                        busy_o,
  output logic [tileBits-1:0]         tile_cnt_o,
  output logic                        ovf_o
);

  localparam logic signed [accBits-1:0] SatMax = accBits'((2 ** (outBits - 1)) - 1);
  localparam logic signed [accBits-1:0] SatMin = accBits'(-(2 ** (outBits - 1)));

  typedef enum logic [0:0] {AccIdle, AccRun} acc_state_e;

  acc_state_e                  state_q, state_d;
  logic [tileBits-1:0]         tile_cnt_q, tile_cnt_d;
  logic [tileBits-1:0]         n_q, n_d;
  logic signed [accBits-1:0]   acc_q [numCols];
  logic signed [accBits-1:0]   acc_d [numCols];
  logic                        out_valid_q, out_valid_d;
  logic [numCols*outBits-1:0]  out_data_q, out_data_d;
  logic                        ovf_q, ovf_d;
  logic                        busy_q;

  logic                        idle, accept, complete, pop, load;
  logic [tileBits-1:0]         n_cfg, n_eff;
  logic [numCols*outBits-1:0]  result;

  // Group control
  always_comb begin
    idle   = (state_q == AccIdle);
    accept = valid_i && !clear_i;
    n_cfg  = cfg_num_tiles;
    if (cfg_num_tiles == '0) begin
      n_cfg = tileBits'(1);
    end else if (cfg_num_tiles > tileBits'(maxTiles)) begin
      n_cfg = tileBits'(maxTiles);
    end
    // The group length is taken from cfg only on its first tile
    n_eff    = idle ? n_cfg : n_q;
    complete = accept && ((tile_cnt_q + tileBits'(1)) == n_eff);
    n_d      = (idle && accept) ? n_cfg : n_q;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= AccIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = AccIdle;
    end else if (accept) begin
      state_d = complete ? AccIdle : AccRun;
    end
  end

  // Accumulate and requantize, per column
  always_comb begin
    logic signed [accBits-1:0] ext;
    logic signed [accBits-1:0] sum;
    logic signed [accBits-1:0] r;
    result = '0;
    for (int c = 0; c < numCols; c++) begin
      ext = {{(accBits - inBits){data_i[c*inBits+inBits-1]}}, data_i[c*inBits +: inBits]};
      sum = idle ? ext : acc_q[c] + ext;
      acc_d[c] = acc_q[c];
      if (clear_i || complete) begin
        acc_d[c] = '0;
      end else if (accept) begin
        acc_d[c] = sum;
      end
      r = sum >>> cfg_shift;
      if (cfg_relu && r[accBits-1]) begin
        r = '0;
      end
      if (r > SatMax) begin
        r = SatMax;
      end else if (r < SatMin) begin
        r = SatMin;
      end
      result[c*outBits +: outBits] = r[outBits-1:0];
    end
  end

  // Counter, output register and overflow flag
  always_comb begin
    pop  = out_valid_q && ready_i;
    load = complete && (!out_valid_q || pop);

    tile_cnt_d = tile_cnt_q;
    if (clear_i) begin
      tile_cnt_d = '0;
    end else if (accept) begin
      tile_cnt_d = complete ? '0 : tile_cnt_q + tileBits'(1);
    end

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = result;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end

    ovf_d = ovf_q || (complete && !load);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tile_cnt_q  <= '0;
      n_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      for (int c = 0; c < numCols; c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      tile_cnt_q  <= tile_cnt_d;
      n_q         <= n_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ovf_q       <= ovf_d;
      busy_q      <= (tile_cnt_d != '0);
      for (int c = 0; c < numCols; c++) begin
        acc_q[c] <= acc_d[c];
      end
    end
  end

  // Outputs
  always_comb begin
    valid_o    = out_valid_q;
    data_o     = out_data_q;
    busy_o     = busy_q;
    tile_cnt_o = tile_cnt_q;
    ovf_o      = ovf_q;
  end

endmodule

// File: tb/tb_qracc_psum_acc.sv
// Directed bench for qracc_psum_acc with hand-computed expected vectors.
module tb_qracc_psum_acc;

  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   cfg_num_tiles;
  logic [3:0]   cfg_shift;
  logic         cfg_relu;
  logic         clear_i;
  logic         valid_i;
  logic [255:0] data_i;
  logic         valid_o;
  logic         ready_i;
  logic [255:0] data_o;
  logic         busy_o;
  logic [4:0]   tile_cnt_o;
  logic         ovf_o;

  int n_cmp = 0;
  int n_bad = 0;

  qracc_psum_acc dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_num_tiles (cfg_num_tiles),
    .cfg_shift     (cfg_shift),
    .cfg_relu      (cfg_relu),
    .clear_i       (clear_i),
    .valid_i       (valid_i),
    .data_i        (data_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .data_o        (data_o),
    .busy_o        (busy_o),
    .tile_cnt_o    (tile_cnt_o),
    .ovf_o         (ovf_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] fill(input logic [7:0] v);
    return {32{v}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one tile for one cycle; results visible on return.
  task automatic send(input logic [255:0] v);
    data_i  = v;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    data_i  = '0;
  endtask

  task automatic pop_one();
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("pop_valid_low", 256'(valid_o), 256'(0));
  endtask

  initial begin
    logic [255:0] v;
    rst = 1'b1; cfg_num_tiles = 5'd1; cfg_shift = 4'd0; cfg_relu = 1'b0;
    clear_i = 1'b0; valid_i = 1'b0; data_i = '0; ready_i = 1'b0;
    #3;
    check("rst_valid", 256'(valid_o), 256'(0));
    check("rst_data", data_o, '0);
    check("rst_busy", 256'(busy_o), 256'(0));
    check("rst_tile_cnt", 256'(tile_cnt_o), 256'(0));
    check("rst_ovf", 256'(ovf_o), 256'(0));
    tick();
    rst = 1'b0;

    // N=1, col0=5, col1=-3
    v = '0; v[7:0] = 8'd5; v[15:8] = 8'hfd;
    send(v);
    check("n1_valid", 256'(valid_o), 256'(1));
    check("n1_data", data_o, v);
    pop_one();

    // N=4, all 100, shift 2 -> 100; then shift 0 -> saturate 127
    cfg_num_tiles = 5'd4; cfg_shift = 4'd2;
    for (int i = 1; i <= 3; i++) begin
      send(fill(8'd100));
      check("n4_busy", 256'(busy_o), 256'(1));
      check("n4_tile_cnt", 256'(tile_cnt_o), 256'(i));
      check("n4_no_valid", 256'(valid_o), 256'(0));
    end
    send(fill(8'd100));
    check("n4_valid", 256'(valid_o), 256'(1));
    check("n4_data_shift2", data_o, fill(8'd100));
    check("n4_idle_busy", 256'(busy_o), 256'(0));
    check("n4_idle_cnt", 256'(tile_cnt_o), 256'(0));
    pop_one();
    cfg_shift = 4'd0;
    for (int i = 0; i < 4; i++) send(fill(8'd100));
    check("n4_data_sat", data_o, fill(8'h7f));
    pop_one();

    // N=2: -3 + -2 = -5 >>> 1 = -3; relu -> 0; -128 + -128 -> -128
    cfg_num_tiles = 5'd2; cfg_shift = 4'd1;
    send(fill(8'hfd)); send(fill(8'hfe));
    check("n2_neg_shift", data_o, fill(8'hfd));
    pop_one();
    cfg_relu = 1'b1;
    send(fill(8'hfd)); send(fill(8'hfe));
    check("n2_relu", data_o, fill(8'h00));
    pop_one();
    cfg_relu = 1'b0; cfg_shift = 4'd0;
    send(fill(8'h80)); send(fill(8'h80));
    check("n2_sat_neg", data_o, fill(8'h80));
    pop_one();

    // Backpressure: N=1, tiles 1,2,3 back-to-back with ready low
    cfg_num_tiles = 5'd1;
    valid_i = 1'b1;
    data_i = fill(8'd1); tick();
    data_i = fill(8'd2); tick();
    data_i = fill(8'd3); tick();
    valid_i = 1'b0; data_i = '0;
    check("bp_valid", 256'(valid_o), 256'(1));
    check("bp_data_held", data_o, fill(8'd1));
    check("bp_ovf", 256'(ovf_o), 256'(1));
    pop_one();

    // Fresh state, then same-cycle pop and load
    rst = 1'b1; #1; rst = 1'b0;
    check("rst2_ovf", 256'(ovf_o), 256'(0));
    send(fill(8'd5));
    check("pl_first", data_o, fill(8'd5));
    ready_i = 1'b1;
    send(fill(8'd7));
    ready_i = 1'b0;
    check("pl_valid", 256'(valid_o), 256'(1));
    check("pl_data", data_o, fill(8'd7));
    check("pl_ovf", 256'(ovf_o), 256'(0));
    pop_one();

    // Clear mid-group, clear beats a simultaneous tile
    cfg_num_tiles = 5'd3;
    send(fill(8'd1)); send(fill(8'd1));
    check("clr_pre_cnt", 256'(tile_cnt_o), 256'(2));
    clear_i = 1'b1;
    send(fill(8'd9));
    clear_i = 1'b0;
    check("clr_cnt", 256'(tile_cnt_o), 256'(0));
    check("clr_busy", 256'(busy_o), 256'(0));
    check("clr_no_out", 256'(valid_o), 256'(0));
    for (int i = 0; i < 3; i++) send(fill(8'd1));
    check("clr_after_data", data_o, fill(8'd3));
    check("clr_after_valid", 256'(valid_o), 256'(1));

    // Asynchronous reset mid-group with the output register full
    send(fill(8'd1));
    check("ar_pre_busy", 256'(busy_o), 256'(1));
    #2 rst = 1'b1;
    #1;
    check("ar_valid", 256'(valid_o), 256'(0));
    check("ar_data", data_o, '0);
    check("ar_busy", 256'(busy_o), 256'(0));
    check("ar_cnt", 256'(tile_cnt_o), 256'(0));
    check("ar_ovf", 256'(ovf_o), 256'(0));
    tick();
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/qracc_psum_acc.md
# qracc_psum_acc

Partial-sum accumulator directly downstream of `seq_acc`. It captures each `mac_data_o` vector on `valid_o` and accumulates `cfg_num_tiles` consecutive vectors, one per 128-row weight tile of a layer wider than the array. It then requantizes the sum (arithmetic shift, optional ReLU, saturation) and presents one output vector on a valid/ready interface. `seq_acc` has no output backpressure, so this block never stalls its input; a completed group that cannot be buffered is dropped and flagged.

## Interface
- `numCols`, 32, vector elements; matches `seq_acc` `outputElements`.
- `inBits`, 8, signed element width of `data_i`; matches `seq_acc` `outputBits`.
- `outBits`, 8, signed element width of `data_o`.
- `maxTiles`, 16, maximum tiles per group.
- `accBits` (localparam), `inBits + $clog2(maxTiles)`. At this width the accumulator cannot overflow.
- `tileBits` (localparam), `$clog2(maxTiles+1)`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_num_tiles`  in  tileBits  tiles per group; 0 is treated as 1; values above `maxTiles` are clamped to `maxTiles`.
- `cfg_shift`  in  4  arithmetic right shift applied to the final sum.
- `cfg_relu`  in  1  when 1, negative results are forced to 0.
- `clear_i`  in  1  synchronous abort of the in-progress group.
- `valid_i`  in  1  input vector strobe; connects to `seq_acc` `valid_o`.
- `data_i`  in  numCols×inBits  signed vector; connects to `seq_acc` `mac_data_o`.
- `valid_o`  out  1  output vector available.
- `ready_i`  in  1  downstream accepts.
- `data_o`  out  numCols×outBits  signed requantized vector.
- `busy_o`  out  1  a group is partially accumulated.
- `tile_cnt_o`  out  tileBits  tiles accumulated in the current group.
- `ovf_o`  out  1  sticky; set when a completed group was dropped.

## Operation
- Accumulator FSM, two states:
  - ACC_IDLE: `tile_cnt`=0.
  - ACC_RUN: 0 < `tile_cnt` < N.
- Input capture:
  - On `valid_i` in ACC_IDLE, N is latched from `cfg_num_tiles` (0→1, clamped), and `acc[c]` ← sign-extended `data_i[c]`.
  - On `valid_i` in ACC_RUN, `acc[c]` ← `acc[c]` + sign-extended `data_i[c]`.
  - `tile_cnt` increments on each accepted tile.
  - Changes to `cfg_*` mid-group have no effect on the group; `cfg_shift` and `cfg_relu` are sampled on the completing tile.
- Group completes when the accepted tile makes `tile_cnt`+1 == N. Then:
  - sum = `acc` + `data_i`, or `data_i` alone if N=1;
  - r = sum >>> `cfg_shift` (arithmetic, rounds toward −inf);
  - if `cfg_relu` and r<0, r=0;
  - saturate r to [−2^(outBits−1), 2^(outBits−1)−1].
  - `tile_cnt` → 0 and the FSM returns to ACC_IDLE.
- Output register, one entry, EMPTY or FULL:
  - On completion, r is loaded if the register is EMPTY or is popped in the same cycle (`valid_o`&&`ready_i`). Otherwise the new result is discarded, the old result is retained, and `ovf_o` is set.
  - Pop when `valid_o`&&`ready_i`.
- `clear_i`: `tile_cnt` → 0, accumulator contents are discarded, and the FSM goes to ACC_IDLE. It does not affect the output register or `ovf_o`. If `clear_i` and `valid_i` are high together, `clear_i` wins and the tile is ignored.
- `ovf_o` is cleared only by `rst`.

## Timing
- Reset, asynchronous on `rst` high:
  - `valid_o`=0, `data_o`=0, `busy_o`=0, `tile_cnt_o`=0, `ovf_o`=0;
  - accumulator zeroed; FSM in ACC_IDLE; output register EMPTY.
- Reset asserted mid-group or with the output register FULL loses all state.
- Latency: completing `valid_i` at edge t → `valid_o`=1 with data after edge t, i.e. 1 cycle.
- The input accepts `valid_i` every cycle, including back-to-back groups.
- `valid_o` holds and `data_o` stays stable until `ready_i`. `valid_o` does not depend combinationally on `ready_i`.
- `busy_o` = (`tile_cnt`≠0), registered. `tile_cnt_o` is updated the cycle after each tile.

## Test plan
- N=1, shift=0, relu=0; `data_i` col0=5, col1=−3, others 0 → next cycle `valid_o`=1, `data_o` col0=5, col1=−3, others 0.
- N=4, four tiles of all-100, shift=2 → single output, all 100 (400>>>2); `busy_o`=1 and `tile_cnt_o`=1,2,3 between tiles. Repeat with shift=0 → all 127 (saturated).
- N=2, tiles −3 and −2, shift=1, relu=0 → −3 (−5>>>1). Same with relu=1 → 0. Tile values −128 and −128 with shift=0 → −128.
- `ready_i`=0, N=1, three back-to-back tiles 1,2,3 → `data_o`=1 held; tiles 2 and 3 dropped; `ovf_o`=1. Raise `ready_i` → one pop of 1, then `valid_o`=0.
- Full register with `ready_i`=1 in the same cycle as a completing tile 7 → old value popped, 7 loaded, `valid_o` stays 1, `ovf_o` stays 0.
- N=3, two tiles, then `clear_i` (with simultaneous `valid_i`=9) → `tile_cnt_o`=0, no output. Next three tiles of 1 → output 3. Assert `rst` mid-group → all outputs 0 immediately (asynchronous).
